// File: rtl/par_rx_deser.sv
// Serial-to-parallel receiver: MSB-first bits framed by sof, reassembled into W-bit words, queued in a FWFT FIFO.
// Word readable the cycle after its last bit; a full FIFO without a pop drops the word and pulses overflow.

module par_rx_deser_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

module par_rx_deser #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din,
    input  logic                     sof,
    output logic [W-1:0]             dout_data,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     frame_err,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int CW = $clog2(W);

    typedef enum logic {HUNT, SHIFT} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [W-2:0]   shift, shift_nxt;
    logic [W-1:0]   shift_cat;
    logic           push_req;
    logic           ferr_nxt;
    logic           pop;
    logic           fifo_empty;
    logic           fifo_full;

    // Holds the W-1 bits received so far with the current bit appended.
    assign shift_cat = {shift, din};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HUNT;
            cnt       <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            shift     <= shift_nxt;
            frame_err <= ferr_nxt;
            overflow  <= push_req && fifo_full && !pop;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift_nxt = shift;
        push_req  = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            HUNT: begin
                if (sof) begin
                    shift_nxt    = '0;
                    shift_nxt[0] = din;
                    cnt_nxt      = CW'(1);
                    state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                if (sof) begin
                    // Restart on the new MSB; the partial word is discarded.
                    ferr_nxt     = 1'b1;
                    shift_nxt    = '0;
                    shift_nxt[0] = din;
                    cnt_nxt      = CW'(1);
                end else if (cnt == CW'(W - 1)) begin
                    push_req  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = HUNT;
                end else begin
                    shift_nxt = shift_cat[W-2:0];
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    assign pop        = dout_valid && dout_ready;
    assign dout_valid = !fifo_empty;

    par_rx_deser_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (shift_cat),
        .pop       (pop),
        .head      (dout_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );
endmodule

// File: tb/tb_par_rx_deser.sv
// Directed bench for par_rx_deser with a queue-based reference model checked every cycle.
module tb_par_rx_deser;
    localparam int W     = 4;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          din = 1'b0;
    logic          sof = 1'b0;
    logic          dout_ready = 1'b0;
    logic [W-1:0]  dout_data;
    logic          dout_valid;
    logic          frame_err;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    int n_chk  = 0;
    int n_pass = 0;

    par_rx_deser #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .sof        (sof),
        .dout_data  (dout_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Reference model: bits collected since the last sof, output queue, registered pulses.
    int m_q[$];
    bit m_in;
    int m_cnt;
    int m_word;
    bit m_ferr;
    bit m_ovf;
    bit m_pop;
    bit m_done;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_q.delete();
                m_in = 0; m_cnt = 0; m_word = 0; m_ferr = 0; m_ovf = 0;
            end else begin
                m_pop  = (m_q.size() > 0) && dout_ready;
                m_done = 0;
                m_ferr = 0;
                if (sof) begin
                    m_ferr = m_in;
                    m_in   = 1;
                    m_word = int'(din);
                    m_cnt  = 1;
                end else if (m_in) begin
                    m_word = m_word * 2 + int'(din);
                    m_cnt  = m_cnt + 1;
                    if (m_cnt == W) begin
                        m_done = 1;
                        m_in   = 0;
                    end
                end
                m_ovf = m_done && (m_q.size() == DEPTH) && !m_pop;
                if (m_pop) void'(m_q.pop_front());
                if (m_done && !m_ovf) m_q.push_back(m_word % (1 << W));
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b1) begin
                chk("model_valid", int'(dout_valid), int'(m_q.size() != 0));
                chk("model_level", int'(fifo_level), m_q.size());
                chk("model_frame_err", int'(frame_err), int'(m_ferr));
                chk("model_overflow", int'(overflow), int'(m_ovf));
                if (m_q.size() != 0) chk("model_data", int'(dout_data), m_q[0]);
            end
        end
    end

    // Inputs change on the falling edge; returns just after the sampling rising edge.
    task automatic drive(input logic s, input logic d, input logic r);
        @(negedge clk);
        sof = s; din = d; dout_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic r);
        for (int i = W - 1; i >= 0; i--) drive(i == W - 1, w[i], r);
    endtask

    logic [W-1:0] stream [4];

    initial begin
        stream[0] = 4'hA; stream[1] = 4'h5; stream[2] = 4'hF; stream[3] = 4'h3;

        #1;
        chk("reset_valid", int'(dout_valid), 0);
        chk("reset_data", int'(dout_data), 0);
        chk("reset_level", int'(fifo_level), 0);
        chk("reset_pulses", int'({frame_err, overflow}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // Basic capture: 1,0,1,0 -> 4'b1010, visible for exactly one cycle.
        drive(1, 1, 1); drive(0, 0, 1); drive(0, 1, 1);
        chk("basic_before_last", int'(dout_valid), 0);
        drive(0, 0, 1);
        chk("basic_valid", int'(dout_valid), 1);
        chk("basic_data", int'(dout_data), 4'hA);
        drive(0, 0, 1);
        chk("basic_one_cycle", int'(dout_valid), 0);

        // Gapless streaming, sof every 4th cycle.
        for (int k = 0; k < 4; k++) begin
            send_word(stream[k], 1);
            chk("stream_data", int'(dout_data), int'(stream[k]));
            chk("stream_no_err", int'({frame_err, dout_valid}), 1);
        end
        drive(0, 0, 1);

        // Frame error: second sof two cycles into a word.
        drive(1, 0, 1); drive(0, 0, 1);
        drive(1, 1, 1);
        chk("ferr_pulse", int'(frame_err), 1);
        drive(0, 1, 1);
        chk("ferr_one_cycle", int'(frame_err), 0);
        drive(0, 0, 1);
        chk("ferr_no_partial", int'(dout_valid), 0);
        drive(0, 0, 1);
        chk("ferr_next_word", int'(dout_data), 4'hC);
        drive(0, 0, 1);

        // Backpressure and overflow.
        send_word(4'h1, 0);
        chk("bp_level1", int'(fifo_level), 1);
        send_word(4'h2, 0);
        chk("bp_level2", int'(fifo_level), 2);
        send_word(4'h3, 0);
        chk("ovf_pulse", int'(overflow), 1);
        chk("ovf_level", int'(fifo_level), 2);
        chk("ovf_head_kept", int'(dout_data), 1);
        drive(0, 0, 1);
        chk("drain_second", int'(dout_data), 2);
        chk("ovf_cleared", int'(overflow), 0);
        drive(0, 0, 1);
        chk("drain_level0", int'(fifo_level), 0);

        // Full FIFO with a pop in the cycle word 3 completes.
        send_word(4'h1, 0);
        send_word(4'h2, 0);
        drive(1, 0, 0); drive(0, 0, 0); drive(0, 1, 0);
        drive(0, 1, 1);
        chk("simul_no_ovf", int'(overflow), 0);
        chk("simul_level", int'(fifo_level), 2);
        chk("simul_head", int'(dout_data), 2);
        drive(0, 0, 1);
        chk("simul_third", int'(dout_data), 3);
        drive(0, 0, 1);
        drive(0, 0, 0);

        // Asynchronous reset mid-word with one word stored.
        send_word(4'h7, 0);
        drive(1, 1, 0); drive(0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", int'(dout_valid), 0);
        chk("arst_level", int'(fifo_level), 0);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 8; i++) drive(0, 1, 1);
        chk("post_reset_no_sof", int'(dout_valid), 0);
        drive(0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
